// File: rtl/arbitrated_ram_pkg.sv
// Shared constants and helpers for the arbitrated RAM.
package arbitrated_ram_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int PARITY_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/arbitrated_ram_rr_arbiter.sv
// Round-robin arbiter; the channel after the last granted one has highest priority.
module rr_arbiter
    import arbitrated_ram_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    output logic [CHANNELS-1:0] grant
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("rr_arbiter: CHANNELS out of range");
    end

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int  idx;
        logic found;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= CHANNELS) idx -= CHANNELS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = (idx == CHANNELS - 1) ? '0 : PW'(idx + 1);
            end
        end
        // Grant is blocked during reset so nothing is accepted while it is held.
        if (!reset) grant = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/arbitrated_ram.sv
// Multi-channel single-port RAM with round-robin access and registered read data.
// Optional per-word even parity: define ARBITRATED_RAM_PARITY_EN.
module arbitrated_ram
    import arbitrated_ram_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 16,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH),
    parameter int CHANNELS     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              req,
    input  logic [CHANNELS-1:0]              write_en,
    input  logic [CHANNELS*ADDRESSWIDTH-1:0] address,
    input  logic [CHANNELS*DATAWIDTH-1:0]    data_in,
    output logic [CHANNELS-1:0]              grant,
    output logic [DATAWIDTH-1:0]             data_out,
    output logic [CHANNELS-1:0]              read_valid,
    output logic                             parity_error
);

`ifdef ARBITRATED_RAM_PARITY_EN
    localparam int WORDW = DATAWIDTH + 1;
`else
    localparam int WORDW = DATAWIDTH;
`endif

    logic                    any_grant, sel_we, in_range;
    logic [ADDRESSWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0]    sel_data;
    logic [WORDW-1:0]        rd_word, wr_word;

    logic [WORDW-1:0]        mem_q [DATADEPTH];
    logic [DATAWIDTH-1:0]    data_out_q, data_out_d;
    logic [CHANNELS-1:0]     read_valid_q, read_valid_d;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    // Grant is one-hot, so OR-ing the gated slices selects the winner.
    always_comb begin
        any_grant = |grant;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_we   = sel_we | write_en[i];
                sel_addr = sel_addr | address[i*ADDRESSWIDTH +: ADDRESSWIDTH];
                sel_data = sel_data | data_in[i*DATAWIDTH +: DATAWIDTH];
            end
        end
        in_range = int'(sel_addr) < DATADEPTH;
        rd_word  = in_range ? mem_q[sel_addr] : '0;
`ifdef ARBITRATED_RAM_PARITY_EN
        wr_word  = {even_parity(PARITY_MAX_W'(sel_data)), sel_data};
`else
        wr_word  = sel_data;
`endif
    end

    // NOTE: the storage array is deliberately not reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (any_grant && sel_we && in_range) mem_q[sel_addr] <= wr_word;
    end

    always_comb begin
        read_valid_d = '0;
        data_out_d   = data_out_q;
        if (any_grant && !sel_we) begin
            read_valid_d = grant;
            data_out_d   = rd_word[DATAWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q   <= '0;
            read_valid_q <= '0;
        end else begin
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
        end
    end

`ifdef ARBITRATED_RAM_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = 1'b0;
        if (any_grant && !sel_we && in_range)
            parity_err_d = rd_word[DATAWIDTH] != even_parity(PARITY_MAX_W'(rd_word[DATAWIDTH-1:0]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end

    assign parity_error = parity_err_q;
`else
    assign parity_error = 1'b0;
`endif

    assign data_out   = data_out_q;
    assign read_valid = read_valid_q;

endmodule

// File: doc/arbitrated_ram.md
ARBITRATED_RAM -- requirements
Module: arbitrated_ram

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter DATADEPTH, default 16, number of words.
REQ-003 The block SHALL have parameter ADDRESSWIDTH, default $clog2(DATADEPTH), address width.
REQ-004 The block SHALL have parameter CHANNELS, default 4, number of requesting channels (1..16).
REQ-005 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port req, input, CHANNELS, per-channel access request.
REQ-008 The block SHALL have port write_en, input, CHANNELS, per-channel operation select (1 write, 0 read).
REQ-009 The block SHALL have port address, input, CHANNELS*ADDRESSWIDTH, per-channel address; channel i in slice [i*ADDRESSWIDTH +: ADDRESSWIDTH].
REQ-010 The block SHALL have port data_in, input, CHANNELS*DATAWIDTH, per-channel write data, sliced as address.
REQ-011 The block SHALL have port grant, output, CHANNELS, one-hot or zero; the access accepted this cycle.
REQ-012 The block SHALL have port data_out, output, DATAWIDTH, shared registered read data.
REQ-013 The block SHALL have port read_valid, output, CHANNELS, one-hot or zero; data_out belongs to the flagged channel.
REQ-014 The block SHALL have port parity_error, output, 1, read parity mismatch flag (see Configuration).

Function
REQ-015 grant SHALL be combinational from req and the priority pointer; at most one bit set; grant[i] only when req[i].
REQ-016 An access SHALL complete on the rising edge where req[i] and grant[i] are both high; a requester holds req, write_en, address and data_in until granted.
REQ-017 Arbitration SHALL be round-robin: highest priority is the channel after the last granted one, wrapping from CHANNELS-1 to 0.
REQ-018 The priority pointer SHALL update only on a cycle with a grant; with req all zero it is unchanged and grant is zero.
REQ-019 A granted write SHALL store data_in slice to address slice on that edge; read_valid stays zero the next cycle.
REQ-020 A granted read SHALL give one-cycle latency: the next cycle read_valid[i] is high for exactly one cycle with data_out = stored word.
REQ-021 A read granted the cycle after a write to the same address SHALL return the newly written data.
REQ-022 Address >= DATADEPTH: a write SHALL be discarded; a read SHALL complete normally with data_out = 0.
REQ-023 data_out SHALL hold its last value while read_valid is zero.
REQ-024 A single channel requesting continuously SHALL be granted every cycle (back-to-back throughput of one access per cycle).

Reset
REQ-025 On reset low, grant SHALL be 0, read_valid 0, data_out 0, parity_error 0, pointer set so channel 0 has highest priority, immediately and asynchronously.
REQ-026 A read granted in the cycle reset asserts SHALL be dropped (no read_valid after release); memory contents SHALL NOT be reset.
REQ-027 Reset deassertion SHALL be taken synchronously to clk by the surrounding system; the block needs no internal synchroniser.

Configuration
REQ-028 Macro ARBITRATED_RAM_PARITY_EN defined: each word SHALL store one extra even-parity bit computed on write; on a read, parity_error SHALL assert alongside read_valid when stored parity mismatches.
REQ-029 Macro ARBITRATED_RAM_PARITY_EN undefined: no parity storage, parity_error SHALL be tied 0, port list unchanged.

Structure
REQ-030 Package arbitrated_ram_pkg SHALL hold the parity function and the CHANNELS upper-limit constant.
REQ-031 Round-robin arbitration SHALL be a sub-module rr_arbiter (parameter CHANNELS; inputs clk, reset, req; output grant); storage and read pipeline remain in arbitrated_ram.

Verification
REQ-032 Reset low with req=4'b1111 -> grant=0, read_valid=0, data_out=0; release -> first grant=4'b0001.
REQ-033 Channel 2 writes 8'hA5 to address 3, then channel 0 reads address 3 -> next cycle read_valid=4'b0001, data_out=8'hA5.
REQ-034 req=4'b1111 held 8 cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-035 DATADEPTH=12, write 8'hFF to address 13, read address 13 -> data_out=0, read_valid set; address 1 unchanged.
REQ-036 With ARBITRATED_RAM_PARITY_EN, force stored parity bit of address 5 inverted, read it -> parity_error=1 with read_valid; without the macro parity_error=0 always.
REQ-037 Reset asserted in the cycle a read of address 0 is granted -> no read_valid after release, memory word retained.
